// File: rtl/block_min_max_tracker_if.sv
// Sample-in / block-result-out bus of the min/max tracker.
// The slave modport is the tracker; the master modport is the environment
// that supplies samples and consumes block results.
interface block_min_max_tracker_if #(
  parameter int W     = 8,
  parameter int IDX_W = 4,
  parameter int LEN_W = 5
);
  logic                    InputValid;
  logic signed [W-1:0]     InputData;
  logic                    InputReady;
  logic                    Flush;
  logic                    ResultValid;
  logic                    ResultReady;
  logic signed [W-1:0]     MinResult;
  logic signed [W-1:0]     MaxResult;
  logic        [IDX_W-1:0] MinIndex;
  logic        [IDX_W-1:0] MaxIndex;
  logic        [LEN_W-1:0] ResultLength;

  modport slave (
    input  InputValid, InputData, Flush, ResultReady,
    output InputReady, ResultValid, MinResult, MaxResult,
           MinIndex, MaxIndex, ResultLength
  );

  modport master (
    output InputValid, InputData, Flush, ResultReady,
    input  InputReady, ResultValid, MinResult, MaxResult,
           MinIndex, MaxIndex, ResultLength
  );
endinterface

// File: rtl/block_min_max_tracker.sv
// Streaming block min/max tracker.
// Accumulates signed samples into blocks of BLOCK_LENGTH and hands the block
// minimum, maximum, their in-block positions and the block length to a
// single registered result slot. A flush emits a partial block early.
// Only the block-completing sample (or a flush) needs a free slot, so the
// source is stalled only when a finished block would otherwise be lost.
module block_min_max_tracker #(
  parameter int INPUT_BIT_WIDTH = 8,
  parameter int BLOCK_LENGTH    = 16,
  parameter int IDX_W           = $clog2(BLOCK_LENGTH),
  parameter int LEN_W           = $clog2(BLOCK_LENGTH + 1)
) (
  input  logic                    Clk,
  input  logic                    ResetN,
  block_min_max_tracker_if.slave  bus
);

  // Accumulator state
  logic        [IDX_W-1:0]           r_count;
  logic signed [INPUT_BIT_WIDTH-1:0] r_min;
  logic signed [INPUT_BIT_WIDTH-1:0] r_max;
  logic        [IDX_W-1:0]           r_min_idx;
  logic        [IDX_W-1:0]           r_max_idx;

  // Result slot
  logic                              r_valid;
  logic signed [INPUT_BIT_WIDTH-1:0] r_res_min;
  logic signed [INPUT_BIT_WIDTH-1:0] r_res_max;
  logic        [IDX_W-1:0]           r_res_min_idx;
  logic        [IDX_W-1:0]           r_res_max_idx;
  logic        [LEN_W-1:0]           r_res_len;

  // Combinational control
  logic                              w_out_free;
  logic                              w_last;
  logic                              w_ready;
  logic                              w_accept;
  logic                              w_complete;
  logic                              w_flush_ok;
  logic                              w_emit;
  logic signed [INPUT_BIT_WIDTH-1:0] w_min_nxt;
  logic signed [INPUT_BIT_WIDTH-1:0] w_max_nxt;
  logic        [IDX_W-1:0]           w_min_idx_nxt;
  logic        [IDX_W-1:0]           w_max_idx_nxt;
  logic        [LEN_W-1:0]           w_len_nxt;

  // Handshake: only the block-completing sample depends on slot space,
  // so InputReady never looks at InputValid or InputData.
  assign w_out_free = !r_valid || bus.ResultReady;
  assign w_last     = (r_count == IDX_W'(BLOCK_LENGTH - 1));
  assign w_ready    = w_out_free || !w_last;
  assign w_accept   = bus.InputValid && w_ready;
  assign w_complete = w_accept && w_last;
  assign w_flush_ok = bus.Flush && w_out_free &&
                      ((r_count != IDX_W'(0)) || w_accept);
  assign w_emit     = w_complete || w_flush_ok;
  assign w_len_nxt  = LEN_W'(r_count) + (w_accept ? LEN_W'(1) : LEN_W'(0));

  // Running extrema including the sample accepted this cycle; strict
  // compares keep the earliest index on ties.
  always_comb begin
    w_min_nxt     = r_min;
    w_max_nxt     = r_max;
    w_min_idx_nxt = r_min_idx;
    w_max_idx_nxt = r_max_idx;
    if (w_accept) begin
      if (r_count == IDX_W'(0)) begin
        w_min_nxt     = bus.InputData;
        w_max_nxt     = bus.InputData;
        w_min_idx_nxt = IDX_W'(0);
        w_max_idx_nxt = IDX_W'(0);
      end else begin
        if (bus.InputData < r_min) begin
          w_min_nxt     = bus.InputData;
          w_min_idx_nxt = r_count;
        end else begin
          w_min_nxt     = r_min;
          w_min_idx_nxt = r_min_idx;
        end
        if (bus.InputData > r_max) begin
          w_max_nxt     = bus.InputData;
          w_max_idx_nxt = r_count;
        end else begin
          w_max_nxt     = r_max;
          w_max_idx_nxt = r_max_idx;
        end
      end
    end else begin
      w_min_nxt     = r_min;
      w_max_nxt     = r_max;
      w_min_idx_nxt = r_min_idx;
      w_max_idx_nxt = r_max_idx;
    end
  end

  // Accumulator: restart on emission, otherwise advance on each accept.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      r_count   <= IDX_W'(0);
      r_min     <= '0;
      r_max     <= '0;
      r_min_idx <= IDX_W'(0);
      r_max_idx <= IDX_W'(0);
    end else if (w_emit) begin
      r_count   <= IDX_W'(0);
      r_min     <= w_min_nxt;
      r_max     <= w_max_nxt;
      r_min_idx <= w_min_idx_nxt;
      r_max_idx <= w_max_idx_nxt;
    end else if (w_accept) begin
      r_count   <= r_count + IDX_W'(1);
      r_min     <= w_min_nxt;
      r_max     <= w_max_nxt;
      r_min_idx <= w_min_idx_nxt;
      r_max_idx <= w_max_idx_nxt;
    end else begin
      r_count   <= r_count;
      r_min     <= r_min;
      r_max     <= r_max;
      r_min_idx <= r_min_idx;
      r_max_idx <= r_max_idx;
    end
  end

  // Result slot: load on emission (only ever when free), clear valid on a
  // plain drain, data fields hold otherwise.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      r_valid       <= 1'b0;
      r_res_min     <= '0;
      r_res_max     <= '0;
      r_res_min_idx <= IDX_W'(0);
      r_res_max_idx <= IDX_W'(0);
      r_res_len     <= LEN_W'(0);
    end else if (w_emit) begin
      r_valid       <= 1'b1;
      r_res_min     <= w_min_nxt;
      r_res_max     <= w_max_nxt;
      r_res_min_idx <= w_min_idx_nxt;
      r_res_max_idx <= w_max_idx_nxt;
      r_res_len     <= w_len_nxt;
    end else if (r_valid && bus.ResultReady) begin
      r_valid       <= 1'b0;
    end else begin
      r_valid       <= r_valid;
    end
  end

  assign bus.InputReady   = w_ready;
  assign bus.ResultValid  = r_valid;
  assign bus.MinResult    = r_res_min;
  assign bus.MaxResult    = r_res_max;
  assign bus.MinIndex     = r_res_min_idx;
  assign bus.MaxIndex     = r_res_max_idx;
  assign bus.ResultLength = r_res_len;

endmodule

// File: tb/tb_block_min_max_tracker.sv
// Directed, table-driven bench for block_min_max_tracker with BLOCK_LENGTH=4.
module tb_block_min_max_tracker;

  localparam int W     = 8;
  localparam int BL    = 4;
  localparam int IDX_W = $clog2(BL);
  localparam int LEN_W = $clog2(BL + 1);

  logic Clk;
  logic ResetN;

  block_min_max_tracker_if #(.W(W), .IDX_W(IDX_W), .LEN_W(LEN_W)) bus ();

  block_min_max_tracker #(
    .INPUT_BIT_WIDTH (W),
    .BLOCK_LENGTH    (BL),
    .IDX_W           (IDX_W),
    .LEN_W           (LEN_W)
  ) dut (
    .Clk    (Clk),
    .ResetN (ResetN),
    .bus    (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic v;
    int   d;
    logic f;
    logic rr;
    logic exp_ready;
    logic exp_rv;
    logic chk;
    int   mn;
    int   mx;
    int   mni;
    int   mxi;
    int   len;
  } vec_t;

  vec_t vq[$];
  int   total;
  int   bad;
  logic seen_ready;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_slot(input string tag, input int mn, input int mx,
                            input int mni, input int mxi, input int len);
    check({tag, " min"},    int'($signed(bus.MinResult)), mn);
    check({tag, " max"},    int'($signed(bus.MaxResult)), mx);
    check({tag, " minidx"}, int'(bus.MinIndex), mni);
    check({tag, " maxidx"}, int'(bus.MaxIndex), mxi);
    check({tag, " len"},    int'(bus.ResultLength), len);
  endtask

  // Drive one cycle of inputs (called just after a rising edge), capture
  // InputReady mid-cycle, then return just after the next rising edge.
  task automatic step(input logic v, input int d, input logic f, input logic rr);
    bus.InputValid  = v;
    bus.InputData   = W'(d);
    bus.Flush       = f;
    bus.ResultReady = rr;
    @(negedge Clk);
    seen_ready = bus.InputReady;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.InputValid  = 1'b0;
    bus.InputData   = '0;
    bus.Flush       = 1'b0;
    bus.ResultReady = 1'b0;
    ResetN          = 1'b0;

    //            v     d     f     rr    rdy   rv    chk   mn    mx   mni mxi len
    // basic block
    vq.push_back('{1'b1,   20, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,    0,   0, 0, 0, 0});
    vq.push_back('{1'b1,    8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,    0,   0, 0, 0, 0});
    vq.push_back('{1'b1,   -5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,    0,   0, 0, 0, 0});
    vq.push_back('{1'b1,    8, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,   -5,  20, 2, 0, 4});
    // ties keep the earliest index
    vq.push_back('{1'b1,    3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,    0,   0, 0, 0, 0});
    vq.push_back('{1'b1,    7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,    0,   0, 0, 0, 0});
    vq.push_back('{1'b1,    7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,    0,   0, 0, 0, 0});
    vq.push_back('{1'b1,    3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,    3,   7, 0, 1, 4});
    // back-pressure: pending result holds, completing sample stalls
    vq.push_back('{1'b1,    1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,    3,   7, 0, 1, 4});
    vq.push_back('{1'b1,    2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,    3,   7, 0, 1, 4});
    vq.push_back('{1'b1,   -3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,    3,   7, 0, 1, 4});
    vq.push_back('{1'b1,    9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,    3,   7, 0, 1, 4});
    vq.push_back('{1'b1,    9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,    3,   7, 0, 1, 4});
    vq.push_back('{1'b1,    9, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,   -3,   9, 2, 3, 4});
    vq.push_back('{1'b0,    0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,    0,   0, 0, 0, 0});
    // flush of a partial block at full signed range, then idle flushes
    vq.push_back('{1'b1, -128, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,    0,   0, 0, 0, 0});
    vq.push_back('{1'b1,  127, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,    0,   0, 0, 0, 0});
    vq.push_back('{1'b0,    0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, -128, 127, 0, 1, 2});
    vq.push_back('{1'b0,    0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,    0,   0, 0, 0, 0});
    vq.push_back('{1'b0,    0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,    0,   0, 0, 0, 0});
    // flush together with an accepted sample
    vq.push_back('{1'b1,   10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,    0,   0, 0, 0, 0});
    vq.push_back('{1'b1,   50, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,   10,  50, 0, 1, 2});
    vq.push_back('{1'b0,    0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,    0,   0, 0, 0, 0});
    // flush blocked by a full slot, honoured once the slot drains
    vq.push_back('{1'b1,    5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1,    5,   5, 0, 0, 1});
    vq.push_back('{1'b1,    6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1,    5,   5, 0, 0, 1});
    vq.push_back('{1'b0,    0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,    6,   6, 0, 0, 1});
    vq.push_back('{1'b0,    0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,    0,   0, 0, 0, 0});

    // reset state
    #12;
    check("reset rvalid", int'(bus.ResultValid), 0);
    check("reset ready", int'(bus.InputReady), 1);
    check_slot("reset", 0, 0, 0, 0, 0);
    @(negedge Clk);
    ResetN = 1'b1;
    @(posedge Clk);
    #1;

    foreach (vq[i]) begin
      step(vq[i].v, vq[i].d, vq[i].f, vq[i].rr);
      check($sformatf("row%0d ready", i), int'(seen_ready), int'(vq[i].exp_ready));
      check($sformatf("row%0d rvalid", i), int'(bus.ResultValid), int'(vq[i].exp_rv));
      if (vq[i].chk) begin
        check_slot($sformatf("row%0d", i), vq[i].mn, vq[i].mx, vq[i].mni,
                   vq[i].mxi, vq[i].len);
      end
    end

    // Reset with a result pending and a block half-filled.
    step(1'b1, 100, 1'b0, 1'b0);
    step(1'b1,  90, 1'b0, 1'b0);
    step(1'b1,  80, 1'b0, 1'b0);
    step(1'b1,  70, 1'b0, 1'b0);
    check("pre-reset rvalid", int'(bus.ResultValid), 1);
    step(1'b1,  60, 1'b0, 1'b0);
    step(1'b1,  50, 1'b0, 1'b0);
    bus.InputValid = 1'b0;
    #2;
    ResetN = 1'b0;
    #1;
    check("async reset rvalid", int'(bus.ResultValid), 0);
    check("async reset ready", int'(bus.InputReady), 1);
    check_slot("async reset", 0, 0, 0, 0, 0);
    @(negedge Clk);
    ResetN = 1'b1;
    @(posedge Clk);
    #1;
    step(1'b1, 1, 1'b0, 1'b1);
    step(1'b1, 2, 1'b0, 1'b1);
    step(1'b1, 3, 1'b0, 1'b1);
    check("post-reset partial rvalid", int'(bus.ResultValid), 0);
    step(1'b1, 4, 1'b0, 1'b1);
    check("post-reset rvalid", int'(bus.ResultValid), 1);
    check_slot("post-reset", 1, 4, 0, 3, 4);
    step(1'b0, 0, 1'b0, 1'b1);
    check("post-reset drain", int'(bus.ResultValid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/block_min_max_tracker.md
# block_min_max_tracker

Streaming extremum stage that consumes signed samples and reports, per block of BLOCK_LENGTH samples, the minimum, the maximum and the in-block index of each. It sits directly downstream of the MinMax comparator stage, reusing the same signed compare rules, and feeds block statistics to consumers through a registered valid/ready output slot. Partial blocks can be force-emitted with Flush.

## Interface
- INPUT_BIT_WIDTH, 8, width of signed samples and results
- BLOCK_LENGTH, 16, samples per block; legal range 2..256
- IDX_W, derived $clog2(BLOCK_LENGTH), index width
- LEN_W, derived $clog2(BLOCK_LENGTH+1), length width
- Clk  input  1  single clock, rising edge
- ResetN  input  1  asynchronous, active-low reset
- InputValid  input  1  sample present on InputData
- InputData  input  INPUT_BIT_WIDTH  signed sample
- InputReady  output  1  stage accepts a sample this cycle
- Flush  input  1  request emission of the current partial block
- ResultValid  output  1  output slot holds a block result
- ResultReady  input  1  consumer takes the result this cycle
- MinResult  output  INPUT_BIT_WIDTH  signed block minimum
- MaxResult  output  INPUT_BIT_WIDTH  signed block maximum
- MinIndex  output  IDX_W  in-block position of MinResult
- MaxIndex  output  IDX_W  in-block position of MaxResult
- ResultLength  output  LEN_W  samples in the block (BLOCK_LENGTH or fewer on flush)

## Operation
- Accumulator: Count (0..BLOCK_LENGTH-1), running Min/Max and indices. Output slot: registered copy of all Result* fields plus ResultValid.
- Accept = InputValid && InputReady. Sample at Count==0 loads Min=Max=InputData, both indices 0.
- Later samples: replace Min only if InputData < Min (signed, strict); replace Max only if InputData > Max (strict). Ties keep the earliest index.
- OutFree = !ResultValid || ResultReady.
- InputReady = OutFree || (Count != BLOCK_LENGTH-1). Only a block-completing sample is back-pressured.
- Block completion: accepted sample at Count==BLOCK_LENGTH-1 → slot loaded with final values (including this sample), ResultLength=BLOCK_LENGTH, ResultValid=1, Count→0.
- Flush: honoured only in a cycle with OutFree and (Count>0 or Accept). Otherwise ignored; the source holds Flush until honoured or drops it. An honoured flush emits the current partial block, including a sample accepted in the same cycle, with ResultLength = number of samples; Count→0.
- Flush with Count==0 and no Accept: no effect, no result.
- A result is never overwritten or dropped. The slot updates only when OutFree.
- Slot drain (ResultValid && ResultReady) with no new result in the same cycle → ResultValid=0; data fields hold.
- Arithmetic is compare-only. No width growth. Full signed range is legal, including -2^(W-1).

## Timing
- Reset (ResetN low, async): ResultValid=0, MinResult=MaxResult=0, MinIndex=MaxIndex=0, ResultLength=0, Count=0. InputReady reads 1 once reset is released.
- Latency: result is visible one cycle after the edge that accepts the completing sample or honours the flush.
- Throughput: one sample per cycle sustained when ResultReady=1. Back-to-back blocks are seamless: the slot is reloaded in the same cycle it drains.
- Simultaneous drain and new completion: slot takes the new result; ResultValid stays 1.
- InputReady is combinational from ResultValid, ResultReady and Count. There is no combinational path from InputValid or InputData.
- Reset mid-block or while a result is pending discards all state. The next accepted sample starts a fresh block at index 0.

## Test plan
- BLOCK_LENGTH=4, samples 20, 8, -5, 8, ResultReady=1 → one cycle after 4th accept: Min=-5 idx 2, Max=20 idx 0, Length=4.
- Ties: samples 3, 7, 7, 3 → Min=3 idx 0, Max=7 idx 1.
- Back-pressure: ResultReady=0 with first result pending; stream 4 more samples → InputReady=0 at Count==3 until ResultReady=1; second result appears the next cycle; no sample lost.
- Flush: samples -128, 127 then Flush with Count==2 → Min=-128 idx 0, Max=127 idx 1, Length=2. Flush with Count==0 and idle → no ResultValid.
- Flush with simultaneous sample 50 at Count==1 (first 10) → Length=2, Max=50 idx 1.
- Assert ResetN low while a result is pending and mid-block → ResultValid drops immediately; next block reports only post-reset samples.
